// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module     : uart_tx_fifo_if
// Description: Core-side bus of the UART transmitter: write strobe, data byte,
//              flow-control status and the serial line.
// Revision   : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if;
    logic       i_wr;
    logic [7:0] i_data;
    logic       o_full;
    logic       o_busy;
    logic       o_uart_tx;

    modport master (
        output i_wr,
        output i_data,
        input  o_full,
        input  o_busy,
        input  o_uart_tx
    );

    modport slave (
        input  i_wr,
        input  i_data,
        output o_full,
        output o_busy,
        output o_uart_tx
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module     : uart_tx_fifo
// Description: Byte FIFO feeding an 8-N-1 / 8-N-2 UART serializer.
// Revision   : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int G_CLOCK_DIV = 16,
    parameter int G_FIFO_AW   = 4,
    parameter int G_NSTOP     = 1
) (
    input  wire logic      i_clk,
    input  wire logic      i_rst,
    uart_tx_fifo_if.slave  bus
);

    localparam int c_DEPTH    = 2 ** G_FIFO_AW;
    localparam int c_CW       = G_FIFO_AW + 1;
    localparam int c_BAUD_MAX = G_NSTOP * G_CLOCK_DIV;
    localparam int c_BW       = $clog2(c_BAUD_MAX);

    localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(G_CLOCK_DIV - 1);
    localparam logic [c_BW-1:0] c_STOP_LAST = c_BW'(c_BAUD_MAX - 1);
    localparam logic [c_CW-1:0] c_FULL_CNT  = c_CW'(c_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t                state_q,  state_d;
    logic [c_BW-1:0]       baud_q,   baud_d;
    logic [2:0]            bit_q,    bit_d;
    logic [7:0]            shift_q,  shift_d;
    logic                  tx_q,     tx_d;
    logic [G_FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [G_FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_CW-1:0]       count_q,  count_d;
    logic [7:0]            mem_q [c_DEPTH];

    logic w_push;
    logic w_pop;
    logic w_not_empty;

    // Full is judged on the registered count, so a same-cycle pop never frees room for a write.
    assign w_push      = bus.i_wr && (count_q != c_FULL_CNT);
    assign w_not_empty = (count_q != '0);

    always_comb begin
        wr_ptr_d = w_push ? wr_ptr_q + G_FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + G_FIFO_AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CW'(1);
            2'b01:   count_d = count_q - c_CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        w_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (w_not_empty) begin
                    w_pop   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = c_BIT_LAST;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (baud_q == '0) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                    baud_d  = c_BIT_LAST;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q - c_BW'(1);
                end
            end
            ST_DATA: begin
                if (baud_q == '0) begin
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        baud_d  = c_STOP_LAST;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        baud_d  = c_BIT_LAST;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - c_BW'(1);
                end
            end
            ST_STOP: begin
                if (baud_q == '0) begin
                    // Chain straight into the next start bit so back-to-back frames have no gap.
                    if (w_not_empty) begin
                        w_pop   = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        baud_d  = c_BIT_LAST;
                        state_d = ST_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - c_BW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= bus.i_data;
        end
    end

    assign bus.o_uart_tx = tx_q;
    assign bus.o_full    = (count_q == c_FULL_CNT);
    assign bus.o_busy    = w_not_empty || (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module     : tb_uart_tx_fifo
// Description: Directed bench for uart_tx_fifo (1 and 2 stop-bit instances).
// Revision   : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [7:0] bb [3] = '{8'h00, 8'hFF, 8'h3C};

    always #5 clk = ~clk;

    uart_tx_fifo_if if1 ();
    uart_tx_fifo_if if2 ();

    uart_tx_fifo #(.G_CLOCK_DIV(4), .G_FIFO_AW(4), .G_NSTOP(1)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if1)
    );

    uart_tx_fifo #(.G_CLOCK_DIV(4), .G_FIFO_AW(4), .G_NSTOP(2)) dut2 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Samples one whole frame, starting with the first start-bit cycle.
    task automatic check_frame(input logic [7:0] b, input int ns, input bit sel, input string tag);
        int   len;
        logic e;
        len = (9 + ns) * 4;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (k < 4)       e = 1'b0;
            else if (k < 36) e = b[(k - 4) / 4];
            else             e = 1'b1;
            chk($sformatf("%s tx[%0d]", tag, k), sel ? if2.o_uart_tx : if1.o_uart_tx, 32'(e));
            chk($sformatf("%s busy[%0d]", tag, k), sel ? if2.o_busy : if1.o_busy, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        if1.i_wr   = 1'b0;
        if1.i_data = 8'h00;
        if2.i_wr   = 1'b0;
        if2.i_data = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst tx",    if1.o_uart_tx, 32'd1);
        chk("rst full",  if1.o_full,    32'd0);
        chk("rst busy",  if1.o_busy,    32'd0);
        chk("rst2 tx",   if2.o_uart_tx, 32'd1);
        chk("rst2 busy", if2.o_busy,    32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single byte 0xA5
        if1.i_wr   = 1'b1;
        if1.i_data = 8'hA5;
        @(posedge clk);
        #1;
        if1.i_wr = 1'b0;
        @(negedge clk);
        chk("single pre tx",   if1.o_uart_tx, 32'd1);
        chk("single pre busy", if1.o_busy,    32'd1);
        chk("single pre full", if1.o_full,    32'd0);
        check_frame(8'hA5, 1, 1'b0, "single");
        @(negedge clk);
        chk("single end busy", if1.o_busy,    32'd0);
        chk("single end tx",   if1.o_uart_tx, 32'd1);

        // Back-to-back 0x00, 0xFF, 0x3C
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    if1.i_wr   = 1'b1;
                    if1.i_data = bb[i];
                    @(negedge clk);
                end
                if1.i_wr = 1'b0;
            end
        join_none
        @(posedge clk);
        @(posedge clk);
        check_frame(8'h00, 1, 1'b0, "b2b0");
        check_frame(8'hFF, 1, 1'b0, "b2b1");
        check_frame(8'h3C, 1, 1'b0, "b2b2");
        @(negedge clk);
        chk("b2b end busy", if1.o_busy, 32'd0);

        // Overflow: 18 writes of 0..17, value 17 dropped
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    if1.i_wr   = 1'b1;
                    if1.i_data = 8'(i);
                    @(posedge clk);
                    #1;
                    chk($sformatf("ovf full after wr %0d", i), if1.o_full, (i >= 16) ? 32'd1 : 32'd0);
                end
                if1.i_wr = 1'b0;
            end
        join_none
        @(posedge clk);
        @(posedge clk);
        check_frame(8'h00, 1, 1'b0, "ovf0");
        // Write coinciding with the stop-to-start pop while full must be dropped
        chk("ovf full before pop", if1.o_full, 32'd1);
        if1.i_wr   = 1'b1;
        if1.i_data = 8'hEE;
        @(posedge clk);
        #1;
        if1.i_wr = 1'b0;
        chk("ovf full after pop+wr", if1.o_full, 32'd0);
        for (int i = 1; i <= 16; i++) begin
            check_frame(8'(i), 1, 1'b0, $sformatf("ovf%0d", i));
        end
        @(negedge clk);
        chk("ovf end busy", if1.o_busy,    32'd0);
        chk("ovf end tx",   if1.o_uart_tx, 32'd1);

        // Two stop bits
        fork
            begin
                if2.i_wr   = 1'b1;
                if2.i_data = 8'h5A;
                @(negedge clk);
                if2.i_data = 8'hC3;
                @(negedge clk);
                if2.i_wr = 1'b0;
            end
        join_none
        @(posedge clk);
        @(posedge clk);
        check_frame(8'h5A, 2, 1'b1, "ns2a");
        check_frame(8'hC3, 2, 1'b1, "ns2b");
        @(negedge clk);
        chk("ns2 end busy", if2.o_busy, 32'd0);

        // Reset mid-frame during data bit 3 of 0xF0
        if1.i_wr   = 1'b1;
        if1.i_data = 8'hF0;
        @(posedge clk);
        #1;
        if1.i_wr = 1'b0;
        repeat (19) @(negedge clk);
        chk("mid tx bit3", if1.o_uart_tx, 32'd0);
        chk("mid busy",    if1.o_busy,    32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid rst tx",   if1.o_uart_tx, 32'd1);
        chk("mid rst busy", if1.o_busy,    32'd0);
        chk("mid rst full", if1.o_full,    32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            chk($sformatf("post rst tx[%0d]", k),   if1.o_uart_tx, 32'd1);
            chk($sformatf("post rst busy[%0d]", k), if1.o_busy,    32'd0);
        end
        if1.i_wr   = 1'b1;
        if1.i_data = 8'h81;
        @(posedge clk);
        #1;
        if1.i_wr = 1'b0;
        @(negedge clk);
        chk("post rst pre tx", if1.o_uart_tx, 32'd1);
        check_frame(8'h81, 1, 1'b0, "post");
        @(negedge clk);
        chk("post end busy", if1.o_busy, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
